reg_file_alu_pipe: RTL and testbench
====================================

Name: reg_file_alu_pipe

Overview:
- Parametrised second-generation register-file/ALU datapath.
- Register file width and depth are generic, and the ALU has 8 operations with a NZCV flags register.
- A registered execute/output stage decouples the block from its consumer via a valid/ready handshake, with operand forwarding around that stage.
- Sits between the instruction sequencer (upstream) and the result consumer/bus (downstream).

Parameters:
- DATA_W, 8, datapath/register width in bits (>=4).
- NUM_REGS, 16, number of registers (power of two, >=2).
- ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream operation present
- in_ready  out  1  block can accept an operation this cycle
- ra1  in  ADDR_W  source A register address
- ra2  in  ADDR_W  source B register address
- wa  in  ADDR_W  destination register address
- imm  in  DATA_W  external/immediate operand
- alu_src  in  1  1: SrcB=imm, 0: SrcB=reg[ra2]
- alu_op  in  3  operation code (alu_op_t)
- reg_write  in  1  write result to reg[wa] at retirement
- flag_write  in  1  update flags at retirement
- out_valid  out  1  result held in output stage
- out_ready  in  1  consumer accepts result
- result  out  DATA_W  output-stage result
- out_wa  out  ADDR_W  destination address of output-stage op
- flags  out  4  architectural {N,Z,C,V}

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, mid-operation included):
  - all registers = 0, flags = 0, out_valid = 0, result = 0, out_wa = 0.
  - Any in-flight op is discarded without retiring.
- Handshake:
  - Accept = in_valid && in_ready; retire = out_valid && out_ready.
  - in_ready = !out_valid || out_ready, giving full throughput: one op per cycle under continuous ready.
  - Latency: an op accepted in cycle t shows out_valid=1 with its result in cycle t+1.
  - out_valid, result and out_wa hold stable while out_valid && !out_ready.
  - On accept, the output stage loads the new op. On retire without accept, out_valid goes to 0.
- Retirement:
  - On retire, reg[wa] <= result if the op had reg_write, and flags <= computed flags if it had flag_write.
  - The register file and flags change only at retirement.
- Forwarding:
  - Operand read is combinational at accept.
  - If out_valid and the output-stage op has reg_write and its out_wa == ra1 (or ra2), that operand comes from result, not from the register file.
  - ADC carry-in likewise uses the output-stage C if that op has flag_write; otherwise it uses flags.C.
  - This holds whether or not the output-stage op retires in the same cycle.
- ALU ops (SrcA = reg[ra1]; SrcB per alu_src; all arithmetic mod 2^DATA_W):
  - 0 ADD: A+B, C = carry out.
  - 1 SUB: A+~B+1, C = carry out (1 means no borrow).
  - 2 AND, 3 OR, 4 XOR: C = 0.
  - 5 ADC: A+B+Cin, C = carry out.
  - 6 SHL: A<<1, C = A[MSB].
  - 7 SHR: logical A>>1, C = A[0].
- Flags:
  - Z = (result==0); N = result[MSB].
  - V = signed overflow for ADD/SUB/ADC; V = 0 otherwise.
- Boundary cases:
  - ra1 == ra2 == out_wa: both operands are forwarded.
  - wa == ra1: allowed; the read uses the pre-op value.
  - An op with reg_write=0 and flag_write=0 still produces result and a handshake.
  - in_valid=0 while out_ready=1 simply drains the output stage.

Decomposition:
- Package reg_file_alu_pkg:
  - alu_op_t enum (3 bits, values above).
  - flags_t packed struct {n,z,c,v}.
  - Op-code constants.
- One sub-module, alu_flags:
  - Combinational; parametrised DATA_W.
  - Inputs a, b, cin, op; outputs y and flags_t.
- Register array, forwarding and handshake logic live in the top module.

Test Plan (DATA_W=8, NUM_REGS=16):
1. Reset then back-to-back ops, out_ready=1:
   - Stimulus: ADD r1=r0+imm 0x05 (alu_src=1), then ADD r2=r1+r1.
   - Response: results 0x05 then 0x0A with no stall (forwarding); r2 = 0x0A after retire; flags Z=0.
2. Carry chain:
   - Stimulus: ADD imm 0xFF to r3=0x01 with flag_write, then ADC r4=r0+r0 immediately.
   - Response: first result 0x00 with Z=1, C=1; ADC result 0x01 via forwarded C.
3. SUB/overflow:
   - Stimulus: r5=0x80, SUB r5-imm 0x01.
   - Response: result 0x7F; N=0, Z=0, C=1, V=1.
4. Back-pressure:
   - Stimulus: out_ready=0 for 3 cycles with in_valid=1.
   - Response: in_ready=0; result and out_wa stable; no register/flag change until out_ready=1, then a single retire.
5. Shifts:
   - Stimulus: r6=0x81; SHL gives 0x02; SHR of 0x81 gives 0x40.
   - Response: C=1 for both.
6. Mid-operation reset:
   - Stimulus: assert reset while out_valid=1 holds a reg_write op to r7.
   - Response: out_valid drops asynchronously, r7 stays 0, flags=0.

Source files
------------

// File: rtl/reg_file_alu_pkg.sv
// Shared types for the register-file/ALU datapath: ALU op codes and the NZCV flag bundle.
package reg_file_alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_ADC = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = OP_ADD,
    ALU_SUB = OP_SUB,
    ALU_AND = OP_AND,
    ALU_OR  = OP_OR,
    ALU_XOR = OP_XOR,
    ALU_ADC = OP_ADC,
    ALU_SHL = OP_SHL,
    ALU_SHR = OP_SHR
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage : reg_file_alu_pkg

// File: rtl/alu_flags.sv
// Combinational ALU: eight operations producing a DATA_W result and NZCV flags.
module alu_flags
  import reg_file_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] y,
  output flags_t            fl
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic            carry;
  logic            ovf;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    sum   = '0;
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = sum[MSB:0];
        carry = sum[DATA_W];
        ovf   = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // Two's-complement subtract; carry out of 1 means no borrow.
        sum   = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        y     = sum[MSB:0];
        carry = sum[DATA_W];
        ovf   = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_ADC: begin
        sum   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        y     = sum[MSB:0];
        carry = sum[DATA_W];
        ovf   = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
      end
      ALU_SHL: begin
        y     = {a[MSB-1:0], 1'b0};
        carry = a[MSB];
      end
      ALU_SHR: begin
        y     = {1'b0, a[MSB:1]};
        carry = a[0];
      end
      default: y = '0;
    endcase
  end

  assign fl.n = y[MSB];
  assign fl.z = (y == '0);
  assign fl.c = carry;
  assign fl.v = ovf;

endmodule : alu_flags

// File: rtl/reg_file_alu_pipe.sv
// Register file + ALU with one registered output stage (valid/ready) and operand forwarding
// around it; architectural registers and flags update only when the output stage retires.
module reg_file_alu_pipe
  import reg_file_alu_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  alu_op_t           alu_op,
  input  logic              reg_write,
  input  logic              flag_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] out_wa,
  output flags_t            flags
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  flags_t            flags_q, flags_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0] out_wa_q, out_wa_d;
  logic              out_rw_q, out_rw_d;
  logic              out_fw_q, out_fw_d;
  flags_t            out_flags_q, out_flags_d;

  logic              accept;
  logic              retire;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] src_b;
  logic              carry_in;
  logic [DATA_W-1:0] alu_y;
  flags_t            alu_fl;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid_q && out_ready;

  // The output-stage op is architecturally older than the one being accepted, so its
  // pending register/flag writes take priority over the stored values.
  assign src_a    = (out_valid_q && out_rw_q && (out_wa_q == ra1)) ? result_q : regs_q[ra1];
  assign reg_b    = (out_valid_q && out_rw_q && (out_wa_q == ra2)) ? result_q : regs_q[ra2];
  assign src_b    = alu_src ? imm : reg_b;
  assign carry_in = (out_valid_q && out_fw_q) ? out_flags_q.c : flags_q.c;

  alu_flags #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a   (src_a),
    .b   (src_b),
    .cin (carry_in),
    .op  (alu_op),
    .y   (alu_y),
    .fl  (alu_fl)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    out_wa_d    = out_wa_q;
    out_rw_d    = out_rw_q;
    out_fw_d    = out_fw_q;
    out_flags_d = out_flags_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_y;
      out_wa_d    = wa;
      out_rw_d    = reg_write;
      out_fw_d    = flag_write;
      out_flags_d = alu_fl;
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end

  assign flags_d = (retire && out_fw_q) ? out_flags_q : flags_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      out_wa_q    <= '0;
      out_rw_q    <= 1'b0;
      out_fw_q    <= 1'b0;
      out_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      out_wa_q    <= out_wa_d;
      out_rw_q    <= out_rw_d;
      out_fw_q    <= out_fw_d;
      out_flags_q <= out_flags_d;
      flags_q     <= flags_d;
    end
  end

  // NOTE: the register array is reset as well, since a cleared register file is architectural state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (retire && out_rw_q) begin
      regs_q[out_wa_q] <= result_q;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_wa    = out_wa_q;
  assign flags     = flags_q;

endmodule : reg_file_alu_pipe

// File: tb/tb_reg_file_alu_pipe.sv
// Scoreboard bench: a sequential architectural model predicts each op's result at issue; a
// monitor pops and compares at every retirement and tracks the architectural flags.
module tb_reg_file_alu_pipe;
  import reg_file_alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] ra1 = '0, ra2 = '0, wa = '0;
  logic [7:0] imm = '0;
  logic       alu_src = 1'b0;
  alu_op_t    alu_op = ALU_ADD;
  logic       reg_write = 1'b0, flag_write = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] out_wa;
  logic [3:0] flags;

  reg_file_alu_pipe #(.DATA_W(8), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ra1(ra1), .ra2(ra2), .wa(wa), .imm(imm), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .flag_write(flag_write), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_wa(out_wa), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] wa;
    logic [3:0] fl;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_regs [16];
  logic [3:0] m_flags = '0;
  logic [3:0] arch_flags = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU on plain integers; flags packed as {N,Z,C,V}.
  function automatic void ref_alu(input int op, input int a, input int b, input int cin,
                                  output logic [7:0] y, output logic [3:0] f);
    int s, ss, sa, sb;
    logic c, v;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    s = 0; ss = 0; c = 1'b0; v = 1'b0;
    case (op)
      0: begin s = a + b;       ss = sa + sb;       c = (s > 255); v = (ss > 127 || ss < -128); end
      1: begin s = a - b;       ss = sa - sb;       c = (a >= b);  v = (ss > 127 || ss < -128); end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: begin s = a + b + cin; ss = sa + sb + cin; c = (s > 255); v = (ss > 127 || ss < -128); end
      6: begin s = a * 2; c = (a >= 128); end
      default: begin s = a / 2; c = (a % 2 == 1); end
    endcase
    y = 8'(s);
    f = {y[7], (y == 8'h00), c, v};
  endfunction

  // Drive one op from posedge+1 until accepted; stall>=0 holds out_ready low for that many
  // cycles, stall<0 randomises out_ready. Returns the number of cycles spent waiting.
  task automatic issue(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                       input logic [7:0] im, input logic src, input int op,
                       input logic rw, input logic fw, input int stall, output int waits);
    logic [7:0] y;
    logic [3:0] f;
    waits = 0;
    in_valid = 1'b1; ra1 = a1; ra2 = a2; wa = w; imm = im; alu_src = src;
    alu_op = alu_op_t'(op[2:0]); reg_write = rw; flag_write = fw;
    forever begin
      if (stall < 0) out_ready = ($urandom_range(0, 3) != 0);
      else           out_ready = (waits >= stall);
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        check("issue_timeout", 32'(waits), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    ref_alu(op, int'(m_regs[a1]), src ? int'(im) : int'(m_regs[a2]), int'(m_flags[1]), y, f);
    if (rw) m_regs[w] = y;
    if (fw) m_flags = f;
    sb_q.push_back('{res: y, wa: w, fl: m_flags});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ready = ($urandom_range(0, 3) != 0);
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_flags = '0;
  endtask

  // Monitor: checks handshake relation, hold stability, flags and retiring results.
  logic       hold_pending = 1'b0;
  logic [7:0] hold_res;
  logic [3:0] hold_wa;
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      arch_flags = '0;
      hold_pending = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      check("flags", 32'(flags), 32'(arch_flags));
      if (hold_pending && out_valid) begin
        check("hold_result", 32'(result), 32'(hold_res));
        check("hold_out_wa", 32'(out_wa), 32'(hold_wa));
      end
      hold_pending = out_valid && !out_ready;
      hold_res = result;
      hold_wa = out_wa;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", 32'(out_wa), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("out_wa", 32'(out_wa), 32'(e.wa));
          arch_flags = e.fl;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [3:0] a1, a2, wd;
    model_reset();
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_out_wa", 32'(out_wa), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back with forwarding, no stall.
    issue(4'd0, 4'd0, 4'd1, 8'h05, 1'b1, 0, 1'b1, 1'b0, 0, w);
    check("t1_stall0", 32'(w), 32'd0);
    issue(4'd1, 4'd1, 4'd2, 8'h00, 1'b0, 0, 1'b1, 1'b1, 0, w);
    check("t1_stall1", 32'(w), 32'd0);
    issue(4'd2, 4'd0, 4'd9, 8'h00, 1'b1, 0, 1'b1, 1'b0, 0, w);

    // Carry chain: forwarded C into ADC.
    issue(4'd0, 4'd0, 4'd3, 8'h01, 1'b1, 0, 1'b1, 1'b0, 0, w);
    issue(4'd3, 4'd0, 4'd8, 8'hFF, 1'b1, 0, 1'b1, 1'b1, 0, w);
    issue(4'd0, 4'd0, 4'd4, 8'h00, 1'b0, 5, 1'b1, 1'b1, 0, w);

    // SUB with signed overflow.
    issue(4'd0, 4'd0, 4'd5, 8'h80, 1'b1, 0, 1'b1, 1'b0, 0, w);
    issue(4'd5, 4'd0, 4'd11, 8'h01, 1'b1, 1, 1'b1, 1'b1, 0, w);

    // Back-pressure: three stalled cycles, then one retire.
    issue(4'd0, 4'd0, 4'd12, 8'h3C, 1'b1, 3, 1'b1, 1'b1, 0, w);
    issue(4'd12, 4'd12, 4'd12, 8'h00, 1'b0, 4, 1'b1, 1'b1, 3, w);
    check("t4_stall3", 32'(w), 32'd3);

    // Shifts; also an op with no writeback.
    issue(4'd0, 4'd0, 4'd6, 8'h81, 1'b1, 0, 1'b1, 1'b0, 0, w);
    issue(4'd6, 4'd0, 4'd10, 8'h00, 1'b1, 6, 1'b1, 1'b1, 0, w);
    issue(4'd6, 4'd0, 4'd13, 8'h00, 1'b1, 7, 1'b0, 1'b1, 0, w);
    issue(4'd6, 4'd6, 4'd6, 8'h00, 1'b0, 2, 1'b0, 1'b0, 0, w);

    // Mid-operation reset with a pending write to r7.
    issue(4'd0, 4'd0, 4'd7, 8'h33, 1'b1, 0, 1'b1, 1'b1, 0, w);
    out_ready = 1'b0;
    #2;
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_result", 32'(result), 32'd0);
    check("t6_out_wa", 32'(out_wa), 32'd0);
    check("t6_flags", 32'(flags), 32'd0);
    model_reset();
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(4'd7, 4'd7, 4'd14, 8'h00, 1'b0, 3, 1'b1, 1'b1, 0, w);

    // Randomised traffic, biased toward a few registers so forwarding hits often.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      if ($urandom_range(0, 1) == 0) begin
        a1 = 4'($urandom_range(0, 3)); a2 = 4'($urandom_range(0, 3)); wd = 4'($urandom_range(0, 3));
      end else begin
        a1 = 4'($urandom_range(0, 15)); a2 = 4'($urandom_range(0, 15)); wd = 4'($urandom_range(0, 15));
      end
      issue(a1, a2, wd, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), -1, w);
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file_alu_pipe
